// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and load/store.
// Data accesses win ties, and pipe_stall holds the pipeline until every request of the current pipeline cycle has been served.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, FETCH = 2'd2} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state, state_nxt;
    logic       dflag, fflag;
    logic       dreq, data_pend, fetch_pend;
    logic       abort, done;
    logic [7:0] wait_cnt;

    assign dreq       = dm_read | dm_write;
    assign data_pend  = dreq & ~dflag;
    assign fetch_pend = if_req & ~fflag;
    assign pipe_stall = data_pend | fetch_pend;
    assign mem_req    = (state != IDLE);
    // An ack in the last allowed wait cycle still completes normally.
    assign abort      = mem_req & ~mem_ack & (wait_cnt == WAIT_LAST);
    assign done       = mem_req & (mem_ack | abort);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_pend)
                    state_nxt = DATA;
                else if (fetch_pend)
                    state_nxt = FETCH;
            end
            DATA, FETCH: begin
                if (done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            dflag       <= 1'b0;
            fflag       <= 1'b0;
            wait_cnt    <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            // The pipeline advances on this edge; a completion below still sets its flag.
            if (!pipe_stall) begin
                dflag <= 1'b0;
                fflag <= 1'b0;
            end
            if (state == IDLE) begin
                wait_cnt <= '0;
                if (data_pend) begin
                    mem_addr  <= dm_addr;
                    mem_we    <= dm_write;
                    mem_wdata <= dm_wdata;
                end else if (fetch_pend) begin
                    mem_addr <= if_addr;
                    mem_we   <= 1'b0;
                end
            end else if (done) begin
                if (!mem_ack)
                    timeout_err <= 1'b1;
                if (state == DATA) begin
                    dflag <= 1'b1;
                    if (!mem_we)
                        dm_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    fflag    <= 1'b1;
                    if_rdata <= mem_ack ? mem_rdata : '0;
                end
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (MAX_WAIT 15 and 4) share stimulus, each checked
// every cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_unified_mem_arbiter;

    logic        CLK = 1'b0;
    logic        rst, if_req, dm_read, dm_write, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
    logic        a_mem_req, a_mem_we, a_pipe_stall, a_timeout_err;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic        b_mem_req, b_mem_we, b_pipe_stall, b_timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit adv;

    always #5 CLK = ~CLK;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) u_a (
        .CLK(CLK), .RESET(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(a_dm_rdata), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pipe_stall(a_pipe_stall), .timeout_err(a_timeout_err));

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) u_b (
        .CLK(CLK), .RESET(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(b_dm_rdata), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pipe_stall(b_pipe_stall), .timeout_err(b_timeout_err));

    // owner: 0 = memory free, 1 = serving a load/store, 2 = serving a fetch
    typedef struct {
        int          owner;
        int          waited;
        bit          dsv, fsv, we, terr;
        logic [31:0] addr, wdata, ifq, dmq;
    } mst_t;

    mst_t ma, mb, ma_n, mb_n;

    function automatic mst_t fresh();
        mst_t s;
        s.owner = 0; s.waited = 0; s.dsv = 0; s.fsv = 0; s.we = 0; s.terr = 0;
        s.addr = '0; s.wdata = '0; s.ifq = '0; s.dmq = '0;
        return s;
    endfunction

    function automatic bit stall_of(input mst_t s);
        return ((dm_read || dm_write) && !s.dsv) || (if_req && !s.fsv);
    endfunction

    function automatic mst_t step(input mst_t s, input int mw);
        mst_t        n;
        logic [31:0] d;
        n = s;
        if (rst) return fresh();
        if (!stall_of(s)) begin n.dsv = 0; n.fsv = 0; end
        if (s.owner == 0) begin
            if ((dm_read || dm_write) && !s.dsv) begin
                n.owner = 1; n.waited = 0; n.addr = dm_addr; n.we = dm_write; n.wdata = dm_wdata;
            end else if (if_req && !s.fsv) begin
                n.owner = 2; n.waited = 0; n.addr = if_addr; n.we = 0;
            end
        end else if (mem_ack || s.waited == mw - 1) begin
            d = mem_ack ? mem_rdata : 32'h0;
            if (!mem_ack) n.terr = 1;
            if (s.owner == 1) begin
                n.dsv = 1;
                if (!s.we) n.dmq = d;
            end else begin
                n.fsv = 1;
                n.ifq = d;
            end
            n.owner = 0;
        end else begin
            n.waited = s.waited + 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mst_t m, input logic [31:0] ifr, input logic [31:0] dmr,
                       input logic [31:0] ma_, input logic [31:0] mwd, input logic mr, input logic mwe,
                       input logic ps, input logic te);
        chk({tag, ".mem_req"},     32'(mr),  32'(m.owner != 0));
        chk({tag, ".pipe_stall"},  32'(ps),  32'(stall_of(m)));
        chk({tag, ".timeout_err"}, 32'(te),  32'(m.terr));
        chk({tag, ".if_rdata"},    ifr,      m.ifq);
        chk({tag, ".dm_rdata"},    dmr,      m.dmq);
        if (m.owner != 0) begin
            chk({tag, ".mem_addr"}, ma_,     m.addr);
            chk({tag, ".mem_we"},   32'(mwe), 32'(m.we));
            if (m.we) chk({tag, ".mem_wdata"}, mwd, m.wdata);
        end
    endtask

    // One clock: compare at the falling edge, advance the models across the rising edge.
    task automatic tick();
        @(negedge CLK);
        cmp("A", ma, a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_req, a_mem_we, a_pipe_stall, a_timeout_err);
        cmp("B", mb, b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_req, b_mem_we, b_pipe_stall, b_timeout_err);
        adv  = !stall_of(ma);
        ma_n = step(ma, 15);
        mb_n = step(mb, 4);
        @(posedge CLK);
        ma = ma_n;
        mb = mb_n;
        #1;
    endtask

    task automatic idle_reqs();
        if_req = 0; dm_read = 0; dm_write = 0; mem_ack = 0;
    endtask

    initial begin
        ma = fresh(); mb = fresh();
        rst = 1; idle_reqs(); if_req = 1;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

        // reset held two cycles with a fetch pending
        tick();
        chk("t1.mem_req", 32'(a_mem_req), 0);
        chk("t1.pipe_stall", 32'(a_pipe_stall), 1);
        chk("t1.if_rdata", a_if_rdata, 0);
        chk("t1.dm_rdata", a_dm_rdata, 0);
        chk("t1.timeout_err", 32'(a_timeout_err), 0);

        // lone fetch, ack in the 4th cycle of mem_req
        rst = 0; if_addr = 32'h40;
        tick();
        repeat (3) tick();
        chk("t2.mem_addr", a_mem_addr, 32'h40);
        chk("t2.mem_we", 32'(a_mem_we), 0);
        mem_ack = 1; mem_rdata = 32'h2002000A;
        tick();
        mem_ack = 0;
        chk("t2.pipe_stall", 32'(a_pipe_stall), 0);
        chk("t2.if_rdata", a_if_rdata, 32'h2002000A);
        if_req = 0;
        tick();

        // load and fetch together, memory acks immediately
        dm_read = 1; dm_addr = 32'h10; if_req = 1; if_addr = 32'h44;
        mem_ack = 1; mem_rdata = 32'h11112222;
        tick();
        chk("t3.mem_addr_d", a_mem_addr, 32'h10);
        tick();
        chk("t3.dm_rdata", a_dm_rdata, 32'h11112222);
        chk("t3.stall_mid", 32'(a_pipe_stall), 1);
        mem_rdata = 32'h33334444;
        tick();
        chk("t3.mem_addr_f", a_mem_addr, 32'h44);
        tick();
        chk("t3.stall_end", 32'(a_pipe_stall), 0);
        chk("t3.if_rdata", a_if_rdata, 32'h33334444);
        idle_reqs();
        tick();

        // store with read+write both high, ack in the 5th cycle
        dm_read = 1; dm_write = 1; dm_addr = 32'h20; dm_wdata = 32'hCAFEF00D;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4.mem_we", 32'(a_mem_we), 1);
            chk("t4.mem_addr", a_mem_addr, 32'h20);
            chk("t4.mem_wdata", a_mem_wdata, 32'hCAFEF00D);
            mem_ack = (i == 4);
            tick();
        end
        chk("t4.dm_rdata", a_dm_rdata, 32'h11112222);
        chk("t4.stall", 32'(a_pipe_stall), 0);
        chk("t4.a_terr", 32'(a_timeout_err), 0);
        chk("t4.b_terr", 32'(b_timeout_err), 1);
        chk("t4.b_dm_rdata", b_dm_rdata, 32'h11112222);
        idle_reqs();
        repeat (3) tick();

        // load never acked: B aborts after 4 wait cycles, A after 15
        dm_read = 1; dm_addr = 32'h30;
        tick();
        repeat (4) tick();
        chk("t5.b_dm_rdata", b_dm_rdata, 0);
        chk("t5.b_stall", 32'(b_pipe_stall), 0);
        chk("t5.a_terr_early", 32'(a_timeout_err), 0);
        repeat (11) tick();
        chk("t5.a_terr", 32'(a_timeout_err), 1);
        chk("t5.a_dm_rdata", a_dm_rdata, 0);
        chk("t5.a_stall", 32'(a_pipe_stall), 0);
        idle_reqs();
        repeat (6) tick();
        chk("t5.a_terr_sticky", 32'(a_timeout_err), 1);

        // reset in the 2nd wait cycle, memory acks one cycle late
        dm_read = 1; dm_addr = 32'h50;
        tick();
        tick();
        rst = 1;
        tick();
        chk("t6.mem_req", 32'(a_mem_req), 0);
        chk("t6.dm_rdata", a_dm_rdata, 0);
        chk("t6.terr", 32'(a_timeout_err), 0);
        rst = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t6.dm_rdata_late", a_dm_rdata, 0);
        chk("t6.regrant", 32'(a_mem_req), 1);
        chk("t6.mem_addr", a_mem_addr, 32'h50);
        mem_rdata = 32'h0BADF00D;
        tick();
        chk("t6.dm_rdata_new", a_dm_rdata, 32'h0BADF00D);
        idle_reqs();
        tick();

        // random pipeline traffic; requests change only when A's pipeline advances
        for (int c = 0; c < 3000; c++) begin
            if (adv) begin
                int k;
                k        = $urandom_range(0, 5);
                if_req   = ($urandom_range(0, 3) != 0);
                if_addr  = $urandom & 32'h3FC;
                dm_read  = (k == 1 || k == 3);
                dm_write = (k == 2 || k == 3);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        idle_reqs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
